cycle_sequencer: RTL

Sequences the Nandy CPU through instruction fetch and its one- or two-cycle execute phases. It owns the instruction register, the `cycle` phase bit and the carry flag that feed the combinational control decoder. It gates register writes through a memory ready/ack handshake. It also provides halt/single-step and a bus-timeout watchdog. It sits between the memory interface and the control decoder, and is the only sequential element of the control path.

---
 rtl/nandy_pkg.sv | 17 +
 rtl/bus_watchdog.sv | 37 +++
 rtl/cycle_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/nandy_pkg.sv
// Shared definitions for the Nandy CPU control path.
package nandy_pkg;

  localparam int INST_W          = 8;
  localparam int WDOG_W          = 8;
  localparam int TIMEOUT_DEFAULT = 15;

  // Sequencer phases; BOOT is the reset state.
  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC0 = 3'd2,
    ST_EXEC1 = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_t;

endpackage : nandy_pkg

// File: rtl/bus_watchdog.sv
// Bus watchdog: counts cycles a memory request stays unacknowledged and
// raises a sticky bus error once the limit is reached.
module bus_watchdog
  import nandy_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,      // sequencer changes state this cycle
  input  logic pending,  // request outstanding and not acknowledged
  output logic expire,   // limit reached this cycle
  output logic bus_err
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count;

  // Expiry fires in the cycle whose wait would bring the count to TIMEOUT.
  assign expire = pending && (count == LIMIT);

  // Wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      bus_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (clr)          count <= '0;
      else if (pending) count <= count + 1'b1;
      if (expire)       bus_err <= 1'b1;
    end
  end

endmodule : bus_watchdog

// File: rtl/cycle_sequencer.sv
// Nandy CPU cycle sequencer: fetch, one/two-phase execute with memory
// stall, carry flag, halt/single-step and bus-timeout handling.
module cycle_sequencer
  import nandy_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] fetch_data,
  input  logic              mem_ack,
  input  logic              m,
  input  logic              wc,
  input  logic              alu_carry,
  input  logic              halt_req,
  input  logic              step,
  output logic [INST_W-1:0] inst,
  output logic              cycle,
  output logic              carry,
  output logic              fetch_req,
  output logic              data_req,
  output logic              pc_inc,
  output logic              exec_en,
  output logic              halted,
  output logic              bus_err
);

  seq_state_t state, state_next;
  logic       step_latch;
  logic       in_exec;
  logic       expire;
  seq_state_t boundary;

  assign in_exec  = (state == ST_EXEC0) || (state == ST_EXEC1);
  // Where an instruction goes once its last execute phase commits.
  assign boundary = (halt_req || step_latch) ? ST_HALT : ST_FETCH;

  // Request/commit strobes decoded from state and the live ack.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    fetch_req = 1'b0;
    data_req  = 1'b0;
    pc_inc    = 1'b0;
    exec_en   = 1'b0;
    halted    = 1'b0;
    unique case (state)
      ST_FETCH: begin
        fetch_req = 1'b1;
        pc_inc    = mem_ack;
      end
      ST_EXEC0, ST_EXEC1: begin
        data_req = m;
        exec_en  = !m || mem_ack;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

  // Next-state selection; also drives the watchdog clear.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_BOOT:  state_next = halt_req ? ST_HALT : ST_FETCH;
      ST_FETCH: begin
        if (mem_ack)     state_next = ST_EXEC0;
        else if (expire) state_next = ST_HALT;
      end
      ST_EXEC0: begin
        if (exec_en)     state_next = inst[7] ? ST_EXEC1 : boundary;
        else if (expire) state_next = ST_HALT;
      end
      ST_EXEC1: begin
        if (exec_en)     state_next = boundary;
        else if (expire) state_next = ST_HALT;
      end
      ST_HALT: begin
        // A bus error parks the sequencer here until reset.
        if (!bus_err && (step || !halt_req)) state_next = ST_FETCH;
      end
      default:  state_next = ST_BOOT;
    endcase
  end

  // State register plus the registered datapath it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      inst       <= '0;
      cycle      <= 1'b0;
      carry      <= 1'b0;
      step_latch <= 1'b0;
    end else begin
      state <= state_next;
      cycle <= (state_next == ST_EXEC1);
      if (state == ST_FETCH && mem_ack) inst <= fetch_data;
      // Commit in EXEC is exactly the edge that leaves that EXEC state.
      if (in_exec && exec_en && wc) carry <= alu_carry;
      // Step arms only from HALT; any return to HALT consumes it.
      if (state == ST_HALT)           step_latch <= step && !bus_err;
      else if (state_next == ST_HALT) step_latch <= 1'b0;
    end
  end

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_next != state),
    .pending ((fetch_req || data_req) && !mem_ack),
    .expire  (expire),
    .bus_err (bus_err)
  );

endmodule : cycle_sequencer
